// File: rtl/alarm_bank.sv
`default_nettype none
// ============================================================================
//  Module   : alarm_bank
//  Brief    : Multi-slot daily alarm engine. Each slot stores an hh:mm:ss
//             alarm time and runs its own DISABLED/ARMED/RINGING/SNOOZED
//             state machine against the live 24-hour time. One clk edge is
//             one second. All outputs are registered from the slot state,
//             so a match sampled on edge t shows on the outputs after t+1.
//  Options  : ALARM_BANK_SNOOZE_EN - when defined, the snooze input and the
//             SNOOZED state are built; otherwise snooze is ignored.
//  Revision : 1.0 - initial release
// ============================================================================
module alarm_bank #(
    parameter int NUM_ALARMS = 4,
    parameter int IDX_W      = 2,
    parameter int RING_SECS  = 60,
    parameter int SNOOZE_MIN = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            current_24_hour,
    input  logic [7:0]            current_24_min,
    input  logic [7:0]            current_24_sec,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [7:0]            wr_hour,
    input  logic [7:0]            wr_min,
    input  logic [7:0]            wr_sec,
    input  logic                  wr_enable,
    input  logic                  snooze,
    input  logic                  dismiss,
    output logic                  alarm_buzzer,
    output logic [NUM_ALARMS-1:0] ringing_mask,
    output logic [NUM_ALARMS-1:0] armed_mask,
    output logic [IDX_W-1:0]      active_idx,
    output logic                  wr_err
);

    // Counter is shared between ring timeout and snooze interval.
    localparam int c_SNOOZE_CYC = SNOOZE_MIN * 60;
    localparam int c_CNT_MAX    = (RING_SECS > c_SNOOZE_CYC) ? RING_SECS : c_SNOOZE_CYC;
    localparam int CNT_W        = $clog2(c_CNT_MAX + 1);

    localparam logic [CNT_W-1:0] c_RING_LOAD = CNT_W'(RING_SECS);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
`ifdef ALARM_BANK_SNOOZE_EN
    localparam logic [CNT_W-1:0] c_SNOOZE_LOAD = CNT_W'(c_SNOOZE_CYC);
`endif

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_RINGING  = 2'd2,
        ST_SNOOZED  = 2'd3
    } slot_state_t;

    logic                  w_idx_ok;
    logic                  w_time_ok;
    logic                  w_wr_ok;
    logic                  w_wr_rej;
    logic [NUM_ALARMS-1:0] w_ring_vec;
    logic [NUM_ALARMS-1:0] w_armed_vec;
    logic [IDX_W-1:0]      w_active_idx;

`ifndef ALARM_BANK_SNOOZE_EN
    // Snooze has no function in this build; keep the port but consume it.
    logic w_unused_snooze;
    assign w_unused_snooze = snooze;
`endif

    // A write is only legal for an existing slot and a valid time of day.
    assign w_idx_ok  = (int'(wr_idx) < NUM_ALARMS);
    assign w_time_ok = (wr_hour <= 8'd23) && (wr_min <= 8'd59) && (wr_sec <= 8'd59);
    assign w_wr_ok   = wr_en && w_idx_ok && w_time_ok;
    assign w_wr_rej  = wr_en && !(w_idx_ok && w_time_ok);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ALARMS; gi++) begin : g_slot
            slot_state_t      r_state;
            slot_state_t      w_state_nxt;
            logic [CNT_W-1:0] r_cnt;
            logic [CNT_W-1:0] w_cnt_nxt;
            logic [7:0]       r_hour;
            logic [7:0]       r_min;
            logic [7:0]       r_sec;
            logic             w_sel;
            logic             w_match;

            assign w_sel   = w_wr_ok && (int'(wr_idx) == gi);
            assign w_match = (current_24_hour == r_hour) &&
                             (current_24_min  == r_min)  &&
                             (current_24_sec  == r_sec);

            // Next-state and counter; a write to this slot wins over everything.
            always_comb begin
                w_state_nxt = r_state;
                w_cnt_nxt   = r_cnt;
                if (w_sel) begin
                    w_state_nxt = wr_enable ? ST_ARMED : ST_DISABLED;
                    w_cnt_nxt   = '0;
                end else begin
                    case (r_state)
                        ST_ARMED: begin
                            if (w_match) begin
                                w_state_nxt = ST_RINGING;
                                w_cnt_nxt   = c_RING_LOAD;
                            end
                        end
                        ST_RINGING: begin
                            if (dismiss) begin
                                w_state_nxt = ST_ARMED;
                                w_cnt_nxt   = '0;
`ifdef ALARM_BANK_SNOOZE_EN
                            end else if (snooze) begin
                                w_state_nxt = ST_SNOOZED;
                                w_cnt_nxt   = c_SNOOZE_LOAD;
`endif
                            end else if (r_cnt <= c_CNT_ONE) begin
                                w_state_nxt = ST_ARMED;
                                w_cnt_nxt   = '0;
                            end else begin
                                w_cnt_nxt = r_cnt - c_CNT_ONE;
                            end
                        end
`ifdef ALARM_BANK_SNOOZE_EN
                        ST_SNOOZED: begin
                            if (dismiss) begin
                                w_state_nxt = ST_ARMED;
                                w_cnt_nxt   = '0;
                            end else if (r_cnt <= c_CNT_ONE) begin
                                w_state_nxt = ST_RINGING;
                                w_cnt_nxt   = c_RING_LOAD;
                            end else begin
                                w_cnt_nxt = r_cnt - c_CNT_ONE;
                            end
                        end
`endif
                        default: begin
                            w_state_nxt = r_state;
                            w_cnt_nxt   = r_cnt;
                        end
                    endcase
                end
            end

            // Slot state, counter and stored alarm time.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_state <= ST_DISABLED;
                    r_cnt   <= '0;
                    r_hour  <= '0;
                    r_min   <= '0;
                    r_sec   <= '0;
                end else begin
                    r_state <= w_state_nxt;
                    r_cnt   <= w_cnt_nxt;
                    if (w_sel) begin
                        r_hour <= wr_hour;
                        r_min  <= wr_min;
                        r_sec  <= wr_sec;
                    end
                end
            end

            assign w_ring_vec[gi]  = (r_state == ST_RINGING);
            assign w_armed_vec[gi] = (r_state != ST_DISABLED);
        end
    endgenerate

    // Lowest-index ringing slot, 0 when nothing rings.
    always_comb begin
        w_active_idx = '0;
        for (int j = NUM_ALARMS - 1; j >= 0; j--) begin
            if (w_ring_vec[j]) begin
                w_active_idx = IDX_W'(j);
            end
        end
    end

    // Output register stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            alarm_buzzer <= 1'b0;
            ringing_mask <= '0;
            armed_mask   <= '0;
            active_idx   <= '0;
            wr_err       <= 1'b0;
        end else begin
            alarm_buzzer <= |w_ring_vec;
            ringing_mask <= w_ring_vec;
            armed_mask   <= w_armed_vec;
            active_idx   <= w_active_idx;
            wr_err       <= w_wr_rej;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alarm_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alarm_bank
//  Brief    : Self-checking bench for alarm_bank. Expectations are queued with
//             the cycle they are due when stimulus is driven and compared on
//             the falling edge of that cycle. A second 3-slot instance covers
//             out-of-range slot index writes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alarm_bank;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] cur_hour, cur_min, cur_sec;
    logic       wr_en;
    logic [1:0] wr_idx;
    logic [7:0] wr_hour, wr_min, wr_sec;
    logic       wr_enable;
    logic       snooze, dismiss;

    logic       buzz;
    logic [3:0] ring, armed;
    logic [1:0] act;
    logic       err;

    logic       unused_buzz3;
    logic [2:0] unused_ring3, unused_armed3;
    logic [1:0] unused_act3;
    logic       err3;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    typedef struct {
        int         due;
        string      tag;
        logic [3:0] ring;
        logic [3:0] armed;
        logic       err;
        logic       err3;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    alarm_bank u_dut (
        .clk(clk), .reset(reset),
        .current_24_hour(cur_hour), .current_24_min(cur_min), .current_24_sec(cur_sec),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_hour(wr_hour), .wr_min(wr_min), .wr_sec(wr_sec),
        .wr_enable(wr_enable), .snooze(snooze), .dismiss(dismiss),
        .alarm_buzzer(buzz), .ringing_mask(ring), .armed_mask(armed),
        .active_idx(act), .wr_err(err)
    );

    alarm_bank #(.NUM_ALARMS(3), .IDX_W(2)) u_dut3 (
        .clk(clk), .reset(reset),
        .current_24_hour(cur_hour), .current_24_min(cur_min), .current_24_sec(cur_sec),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_hour(wr_hour), .wr_min(wr_min), .wr_sec(wr_sec),
        .wr_enable(wr_enable), .snooze(snooze), .dismiss(dismiss),
        .alarm_buzzer(unused_buzz3), .ringing_mask(unused_ring3), .armed_mask(unused_armed3),
        .active_idx(unused_act3), .wr_err(err3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [1:0] low_idx(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int k = 3; k >= 0; k--) if (m[k]) r = 2'(k);
        return r;
    endfunction

    // Compare every expectation due in the current cycle.
    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].due <= cyc) begin
                mon_e = q[i];
                q.delete(i);
                if (mon_e.due < cyc) check_val({mon_e.tag, "_late"}, 32'(cyc), 32'(mon_e.due));
                check_val({mon_e.tag, "_ring"},  32'(ring),  32'(mon_e.ring));
                check_val({mon_e.tag, "_armed"}, 32'(armed), 32'(mon_e.armed));
                check_val({mon_e.tag, "_buzz"},  32'(buzz),  32'(|mon_e.ring));
                check_val({mon_e.tag, "_idx"},   32'(act),   32'(low_idx(mon_e.ring)));
                check_val({mon_e.tag, "_err"},   32'(err),   32'(mon_e.err));
                check_val({mon_e.tag, "_err3"},  32'(err3),  32'(mon_e.err3));
            end
        end
    end

    task automatic expect_at(input int d, input string tag, input logic [3:0] r,
                             input logic [3:0] a, input logic e, input logic e3);
        exp_t x;
        x.due = cyc + d; x.tag = tag; x.ring = r; x.armed = a; x.err = e; x.err3 = e3;
        q.push_back(x);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        cur_hour = h; cur_min = m; cur_sec = s;
    endtask

    task automatic idle_time();
        set_time(8'd12, 8'd34, 8'd56);
    endtask

    task automatic write_slot(input logic [1:0] idx, input logic [7:0] h, input logic [7:0] m,
                              input logic [7:0] s, input logic en);
        wr_idx = idx; wr_hour = h; wr_min = m; wr_sec = s; wr_enable = en; wr_en = 1'b1;
        tick(1);
        wr_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_hour = '0; wr_min = '0; wr_sec = '0;
        wr_enable = 1'b0; snooze = 1'b0; dismiss = 1'b0;
        idle_time();
        tick(2);

        // Reset state
        expect_at(1, "rst", 4'b0000, 4'b0000, 1'b0, 1'b0);
        expect_at(2, "rst2", 4'b0000, 4'b0000, 1'b0, 1'b0);
        tick(1);
        reset = 1'b0;
        tick(2);

        // Single slot ring and auto-timeout after RING_SECS
        expect_at(1, "wr1", 4'b0000, 4'b0000, 1'b0, 1'b0);
        expect_at(2, "wr1_arm", 4'b0000, 4'b0010, 1'b0, 1'b0);
        write_slot(2'd1, 8'd7, 8'd30, 8'd0, 1'b1);
        tick(1);
        set_time(8'd7, 8'd30, 8'd0);
        expect_at(1, "s1_lat", 4'b0000, 4'b0010, 1'b0, 1'b0);
        expect_at(2, "s1_ring", 4'b0010, 4'b0010, 1'b0, 1'b0);
        expect_at(61, "s1_last", 4'b0010, 4'b0010, 1'b0, 1'b0);
        expect_at(62, "s1_off", 4'b0000, 4'b0010, 1'b0, 1'b0);
        tick(1);
        idle_time();
        tick(61);

        // Two slots ringing together, dismissed by one pulse
        write_slot(2'd0, 8'd6, 8'd0, 8'd0, 1'b1);
        write_slot(2'd2, 8'd6, 8'd0, 8'd0, 1'b1);
        tick(1);
        set_time(8'd6, 8'd0, 8'd0);
        expect_at(2, "s2_both", 4'b0101, 4'b0111, 1'b0, 1'b0);
        tick(1);
        idle_time();
        tick(1);
        dismiss = 1'b1;
        expect_at(1, "s2_hold", 4'b0101, 4'b0111, 1'b0, 1'b0);
        expect_at(2, "s2_dism", 4'b0000, 4'b0111, 1'b0, 1'b0);
        tick(1);
        dismiss = 1'b0;
        tick(3);

        // Slot 3 ring, snooze behaviour
        write_slot(2'd3, 8'd8, 8'd0, 8'd0, 1'b1);
        tick(1);
        set_time(8'd8, 8'd0, 8'd0);
        expect_at(2, "s3_ring", 4'b1000, 4'b1111, 1'b0, 1'b0);
        tick(1);
        idle_time();
        tick(1);
`ifdef ALARM_BANK_SNOOZE_EN
        snooze = 1'b1;
        expect_at(1, "s3_pre", 4'b1000, 4'b1111, 1'b0, 1'b0);
        expect_at(2, "s3_snz", 4'b0000, 4'b1111, 1'b0, 1'b0);
        expect_at(150, "s3_mid", 4'b0000, 4'b1111, 1'b0, 1'b0);
        expect_at(301, "s3_end", 4'b0000, 4'b1111, 1'b0, 1'b0);
        expect_at(302, "s3_rering", 4'b1000, 4'b1111, 1'b0, 1'b0);
        tick(5);
        snooze = 1'b0;
        tick(297);
        snooze = 1'b1;
        dismiss = 1'b1;
        expect_at(1, "s3_both_hold", 4'b1000, 4'b1111, 1'b0, 1'b0);
        expect_at(2, "s3_both", 4'b0000, 4'b1111, 1'b0, 1'b0);
        expect_at(20, "s3_noring", 4'b0000, 4'b1111, 1'b0, 1'b0);
        tick(1);
        snooze = 1'b0;
        dismiss = 1'b0;
        tick(20);
`else
        snooze = 1'b1;
        expect_at(2, "s3_nosnz", 4'b1000, 4'b1111, 1'b0, 1'b0);
        tick(1);
        snooze = 1'b0;
        tick(1);
        dismiss = 1'b1;
        expect_at(2, "s3_dism", 4'b0000, 4'b1111, 1'b0, 1'b0);
        tick(1);
        dismiss = 1'b0;
        tick(3);
`endif

        // Rejected writes and the legal boundary time
        expect_at(1, "e_hour", 4'b0000, 4'b1111, 1'b1, 1'b1);
        expect_at(2, "e_hour_clr", 4'b0000, 4'b1111, 1'b0, 1'b0);
        write_slot(2'd0, 8'd24, 8'd0, 8'd0, 1'b1);
        tick(1);
        expect_at(1, "e_idx", 4'b0000, 4'b1111, 1'b0, 1'b1);
        expect_at(2, "e_idx_clr", 4'b0000, 4'b1111, 1'b0, 1'b0);
        write_slot(2'd3, 8'd9, 8'd0, 8'd0, 1'b1);
        tick(1);
        expect_at(1, "e_min", 4'b0000, 4'b1111, 1'b1, 1'b1);
        write_slot(2'd0, 8'd6, 8'd60, 8'd0, 1'b1);
        tick(1);
        expect_at(1, "e_sec", 4'b0000, 4'b1111, 1'b1, 1'b1);
        write_slot(2'd0, 8'd6, 8'd0, 8'd60, 1'b1);
        tick(1);
        expect_at(1, "e_edge", 4'b0000, 4'b1111, 1'b0, 1'b0);
        expect_at(2, "e_edge2", 4'b0000, 4'b1111, 1'b0, 1'b0);
        write_slot(2'd2, 8'd23, 8'd59, 8'd59, 1'b1);
        tick(3);

        // Disabling write while slot 0 rings
        set_time(8'd6, 8'd0, 8'd0);
        expect_at(2, "s5_ring", 4'b0001, 4'b1111, 1'b0, 1'b0);
        tick(1);
        idle_time();
        tick(1);
        expect_at(1, "s5_hold", 4'b0001, 4'b1111, 1'b0, 1'b0);
        expect_at(2, "s5_off", 4'b0000, 4'b1110, 1'b0, 1'b0);
        write_slot(2'd0, 8'd6, 8'd0, 8'd0, 1'b0);
        tick(2);
        set_time(8'd6, 8'd0, 8'd0);
        expect_at(2, "s5_noring", 4'b0000, 4'b1110, 1'b0, 1'b0);
        tick(1);
        idle_time();
        tick(3);

        // Reset on the 10th ringing cycle
        set_time(8'd7, 8'd30, 8'd0);
        expect_at(2, "s6_ring", 4'b0010, 4'b1110, 1'b0, 1'b0);
        expect_at(11, "s6_ring10", 4'b0010, 4'b1110, 1'b0, 1'b0);
        tick(1);
        idle_time();
        tick(10);
        reset = 1'b1;
        expect_at(1, "s6_rst", 4'b0000, 4'b0000, 1'b0, 1'b0);
        tick(1);
        reset = 1'b0;
        tick(1);
        set_time(8'd7, 8'd30, 8'd0);
        expect_at(2, "s6_noring", 4'b0000, 4'b0000, 1'b0, 1'b0);
        tick(1);
        idle_time();
        tick(3);

        for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
        check_val("drain", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alarm_bank.md
# alarm_bank

Multi-slot alarm engine: the parametrised successor to the single-compare alarm. It holds NUM_ALARMS independently programmable daily alarms, compares each against the running 24-hour time, and drives a shared buzzer. Each slot runs its own ring/snooze state machine with a bounded ring duration. It sits beside the clock and date handlers in main_driver and consumes current_24_hour/min/sec directly. One clk edge equals one second of time.

## Interface
- NUM_ALARMS, 4: number of alarm slots (1..16).
- IDX_W, 2: width of slot index; must satisfy 2^IDX_W >= NUM_ALARMS.
- RING_SECS, 60: cycles a slot rings before auto-dismiss (>=1).
- SNOOZE_MIN, 5: snooze length in minutes (>=1).

- clk  in  1  system clock, one edge per second.
- reset  in  1  synchronous, active-high reset.
- current_24_hour  in  8  live hour, 0..23.
- current_24_min  in  8  live minute, 0..59.
- current_24_sec  in  8  live second, 0..59.
- wr_en  in  1  program slot wr_idx this cycle.
- wr_idx  in  IDX_W  slot to program.
- wr_hour / wr_min / wr_sec  in  8 each  alarm time.
- wr_enable  in  1  1 = slot armed after write, 0 = disabled.
- snooze  in  1  level; snoozes all RINGING slots.
- dismiss  in  1  level; dismisses all RINGING and SNOOZED slots.
- alarm_buzzer  out  1  registered OR of ringing_mask.
- ringing_mask  out  NUM_ALARMS  bit i set while slot i is RINGING.
- armed_mask  out  NUM_ALARMS  bit i set while slot i is not DISABLED.
- active_idx  out  IDX_W  lowest-index ringing slot; 0 when none.
- wr_err  out  1  one-cycle pulse: rejected write.

## Operation
- Per-slot state: DISABLED, ARMED, RINGING, SNOOZED. Per-slot stored time (hour/min/sec) and a shared-width counter sized $clog2(max(RING_SECS, SNOOZE_MIN*60)+1).
- Reset: all slots DISABLED, stored times 0, counters 0; every output 0.
- Write: accepted only if wr_idx < NUM_ALARMS, wr_hour <= 23, wr_min <= 59, wr_sec <= 59. Accepted: load time, counter cleared, state ARMED if wr_enable else DISABLED. Rejected: no state change, wr_err = 1 next cycle. A write overrides every other event for that slot in the same cycle.
- ARMED -> RINGING when the current time equals the stored time; counter loaded with RING_SECS.
- RINGING: counter decrements each cycle; at 1 -> ARMED (auto-dismiss). dismiss -> ARMED. snooze -> SNOOZED, counter loaded with SNOOZE_MIN*60. dismiss has priority over snooze.
- SNOOZED: counter decrements; at 1 -> RINGING with counter RING_SECS. dismiss -> ARMED.
- Time matches are ignored in RINGING and SNOOZED (no restart, no retrigger).
- Slots repeat daily: ARMED persists after dismiss or timeout.
- Multiple slots may ring simultaneously; snooze/dismiss act on all eligible slots.

## Timing
- All outputs registered; match sampled at edge t -> ringing_mask bit, alarm_buzzer and active_idx valid after edge t+1 (1-cycle latency).
- Ring lasts exactly RING_SECS cycles absent snooze/dismiss.
- Snooze/dismiss sampled on the edge; effect visible next cycle. Holding snooze high has no further effect once slots are SNOOZED.
- Write visible in armed_mask one cycle after wr_en.
- Reset asserted mid-ring clears everything on the next edge; buzzer low after that edge.

## Configuration
- ALARM_BANK_SNOOZE_EN defined: snooze input honoured, SNOOZED state present as above.
- Not defined: snooze input ignored, SNOOZED state and snooze counter logic not built; RINGING exits only via dismiss, timeout, write or reset.

## Test plan
- Write slot 1 = 07:30:00 enabled, drive time 07:30:00 -> ringing_mask = 4'b0010, active_idx = 1, buzzer = 1 next cycle; low after exactly 60 cycles; armed_mask bit 1 stays 1.
- Slots 0 and 2 both = 06:00:00, match -> ringing_mask = 4'b0101, active_idx = 0; dismiss one cycle -> mask 0, both still armed.
- Ringing slot 3, snooze (ALARM_BANK_SNOOZE_EN) -> mask 0 for 300 cycles, then bit 3 rings again; snooze and dismiss same cycle -> ARMED, no re-ring.
- Write wr_hour = 24 or wr_idx beyond NUM_ALARMS (NUM_ALARMS = 3) -> wr_err pulse one cycle, masks unchanged.
- Write slot 0 with wr_enable = 0 while it rings -> buzzer low next cycle, armed_mask bit 0 = 0; later match -> no ring.
- Reset asserted on 10th ringing cycle -> all outputs 0 after that edge; match afterwards -> no ring (slots DISABLED).
